cordic_mul_arbiter: RTL

Round-robin arbiter and sequencer that shares one 8-bit CORDIC multiplier (start/x/z in, y/done out) among NUM_REQ requesters.
- Accepts one request at a time and latches its operands.
- Holds the multiplier's start high for the whole operation, captures y on done, then returns the result tagged with the requester ID.
- Drops start for at least one cycle between jobs, because the multiplier clears its internal state whenever start is low.

---
 rtl/cordic_mul_arb_pkg.sv | 14 +
 rtl/rr_arbiter_core.sv | 43 ++++
 rtl/cordic_mul_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cordic_mul_arb_pkg.sv
// Shared types and constants for the CORDIC multiplier arbiter.
package cordic_mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DATA_W             = 8;
    localparam int RES_W              = 16;
    localparam int TIMEOUT_CYCLES_DEF = 24;

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter_core #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    localparam int SW = ID_W + 1;

    logic [ID_W-1:0] cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // Candidate index for each offset from the pointer; ptr is always < NUM_REQ,
    // so one conditional subtract is enough for the wrap.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [SW-1:0] sum;
            assign sum       = {1'b0, ptr} + SW'(gi);
            assign cand[gi]  = (sum >= SW'(NUM_REQ)) ? ID_W'(sum - SW'(NUM_REQ))
                                                      : ID_W'(sum);
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    // Lowest offset with a pending request wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
                any = 1'b1;
            end
        end
        grant = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/cordic_mul_arbiter.sv
// Shares one 8-bit CORDIC multiplier among NUM_REQ requesters, round-robin.
// Optional watchdog in RUN enabled by defining CMA_TIMEOUT_EN.
module cordic_mul_arbiter
    import cordic_mul_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [DATA_W*NUM_REQ-1:0] req_x,
    input  logic [DATA_W*NUM_REQ-1:0] req_z,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [RES_W-1:0]          resp_y,
    output logic                      resp_err,
    output logic                      busy,
    output logic                      mul_start,
    output logic [DATA_W-1:0]         mul_x,
    output logic [DATA_W-1:0]         mul_z,
    input  logic [RES_W-1:0]          mul_y,
    input  logic                      mul_done
);

    state_t state_reg, state_next;

    logic [ID_W-1:0]   rr_ptr_reg;
    logic [DATA_W-1:0] x_reg, z_reg;
    logic [ID_W-1:0]   id_reg;
    logic [RES_W-1:0]  resp_y_reg;
    logic [ID_W-1:0]   resp_id_reg;

    logic load_job, capture;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;

    logic [DATA_W-1:0] x_arr [NUM_REQ];
    logic [DATA_W-1:0] z_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign x_arr[gi] = req_x[gi*DATA_W +: DATA_W];
            assign z_arr[gi] = req_z[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter_core #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

`ifdef CMA_TIMEOUT_EN
    logic [7:0] tmo_cnt_reg;
    logic       tmo_hit;
    logic       resp_err_reg;

    assign tmo_hit  = (tmo_cnt_reg == 8'(TIMEOUT_CYCLES - 1));
    assign resp_err = resp_err_reg;

    // Watchdog: cleared when a job is loaded, counts every RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt_reg <= '0;
        end else if (load_job) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == RUN) begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
        end
    end
`else
    assign resp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and control outputs; start is low outside RUN so the
    // multiplier clears between jobs.
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        mul_start  = 1'b0;
        resp_valid = 1'b0;
        load_job   = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    req_ready  = grant;
                    load_job   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                mul_start = 1'b1;
                if (mul_done) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
`ifdef CMA_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_next = RESP;
                end
`endif
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Job latches, pointer advance and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_reg  <= '0;
            x_reg       <= '0;
            z_reg       <= '0;
            id_reg      <= '0;
            resp_y_reg  <= '0;
            resp_id_reg <= '0;
`ifdef CMA_TIMEOUT_EN
            resp_err_reg <= 1'b0;
`endif
        end else begin
            if (load_job) begin
                x_reg      <= x_arr[grant_idx];
                z_reg      <= z_arr[grant_idx];
                id_reg     <= grant_idx;
                rr_ptr_reg <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (capture) begin
                resp_y_reg  <= mul_y;
                resp_id_reg <= id_reg;
`ifdef CMA_TIMEOUT_EN
                resp_err_reg <= 1'b0;
`endif
            end
`ifdef CMA_TIMEOUT_EN
            else if (state_reg == RUN && tmo_hit) begin
                resp_y_reg   <= '0;
                resp_id_reg  <= id_reg;
                resp_err_reg <= 1'b1;
            end
`endif
        end
    end

    assign mul_x   = x_reg;
    assign mul_z   = z_reg;
    assign resp_y  = resp_y_reg;
    assign resp_id = resp_id_reg;
    assign busy    = (state_reg != IDLE);

endmodule
